// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer for the ASIP. Steps each instruction through
// fetch/decode/exec/mem/wb, waits on memory and the MODMUL unit, and halts on faults.
module multicycle_control_unit #(
    parameter int OP_W     = 4,
    parameter int FN_W     = 2,
    parameter int WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] OpCode,
    input  logic [FN_W-1:0] Funct,
    input  logic            Zero,
    input  logic            Mem_Ready,
    input  logic            Mul_Done,
    output logic [1:0]      Branch,
    output logic [1:0]      Ext_Sel,
    output logic            Opb_Sel,
    output logic            Alu_Func,
    output logic [1:0]      WD_Sel,
    output logic            WR_En,
    output logic            WM_En,
    output logic            IR_En,
    output logic            PC_En,
    output logic            Take_Branch,
    output logic            Flag_En,
    output logic            Mem_Req,
    output logic            Mul_Start,
    output logic            Illegal,
    output logic            Bus_Err,
    output logic            Halted
);

    // state   | meaning
    // FETCH   | request instruction word, wait for Mem_Ready
    // DECODE  | latch decode word and instruction class
    // EXEC    | ALU/CMP/branch completion, or launch of LDR/STR
    // MEM     | data access, wait for Mem_Ready
    // WB      | load result write-back
    // MULWAIT | MODMUL running, wait for Mul_Done
    // HALT    | illegal opcode or watchdog timeout; left only by reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULWAIT, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_CMP, C_LDR, C_STR, C_BR, C_NOP, C_MUL, C_ILL
    } cls_t;

    localparam int              WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WAIT_MAX - 1);
    localparam logic [7:0]      NOP_WORD = 8'b11_11_0_0_00;

    state_t          state_q, state_n;
    cls_t            cls_q, cls_n;
    logic [7:0]      dec_q, dec_n;
    logic            z_q;
    logic            ill_q, bus_err_q;
    logic            set_ill, set_bus_err;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_tc;
    logic            take;

    // word layout: {Branch, Ext_Sel, Opb_Sel, Alu_Func, WD_Sel}
    always_comb begin
        dec_n = NOP_WORD;
        cls_n = C_ILL;
        if (OpCode == OP_W'(0)) begin
            cls_n = C_ALU;
            case (Funct)
                FN_W'(0): dec_n = 8'b11_00_0_0_00;
                FN_W'(1): dec_n = 8'b11_01_1_0_00;
                FN_W'(2): dec_n = 8'b11_00_0_1_00;
                FN_W'(3): dec_n = 8'b11_01_1_1_00;
                default:  cls_n = C_ILL;
            endcase
        end else if (OpCode == OP_W'(1)) begin
            cls_n = C_CMP;
            case (Funct)
                FN_W'(2): dec_n = 8'b11_00_0_1_00;
                FN_W'(3): dec_n = 8'b11_01_1_1_00;
                default:  cls_n = C_ILL;
            endcase
        end else if (OpCode == OP_W'(2)) begin
            cls_n = C_LDR;
            dec_n = 8'b11_10_1_0_01;
        end else if (OpCode == OP_W'(3)) begin
            cls_n = C_STR;
            dec_n = 8'b11_10_1_0_00;
        end else if (OpCode == OP_W'(4)) begin
            cls_n = C_BR;
            dec_n = 8'b00_11_0_0_00;
        end else if (OpCode == OP_W'(5)) begin
            cls_n = C_BR;
            dec_n = 8'b01_11_0_0_00;
        end else if (OpCode == OP_W'(6)) begin
            cls_n = C_BR;
            dec_n = 8'b10_11_0_0_00;
        end else if (OpCode == OP_W'(7)) begin
            cls_n = C_NOP;
        end else if (OpCode == OP_W'(8)) begin
            cls_n = C_MUL;
            dec_n = 8'b11_00_0_0_10;
        end
        if (cls_n == C_ILL) begin
            dec_n = NOP_WORD;
        end
    end

    assign {Branch, Ext_Sel, Opb_Sel, Alu_Func, WD_Sel} = dec_q;

    // Branch decision uses the flag as it stood before this EXEC cycle
    assign take = (dec_q[7:6] == 2'b10) ||
                  ((dec_q[7:6] == 2'b00) && z_q) ||
                  ((dec_q[7:6] == 2'b01) && !z_q);

    assign wd_tc = (wd_cnt == WD_LAST);

    always_comb begin
        state_n     = state_q;
        WR_En       = 1'b0;
        WM_En       = 1'b0;
        IR_En       = 1'b0;
        PC_En       = 1'b0;
        Take_Branch = 1'b0;
        Flag_En     = 1'b0;
        Mem_Req     = 1'b0;
        Mul_Start   = 1'b0;
        set_ill     = 1'b0;
        set_bus_err = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                Mem_Req = 1'b1;
                if (Mem_Ready) begin
                    IR_En   = 1'b1;
                    state_n = S_DECODE;
                end else if (wd_tc) begin
                    set_bus_err = 1'b1;
                    state_n     = S_HALT;
                end
            end
            S_DECODE: begin
                unique case (cls_n)
                    C_ILL: begin
                        set_ill = 1'b1;
                        state_n = S_HALT;
                    end
                    C_NOP: begin
                        PC_En   = 1'b1;
                        state_n = S_FETCH;
                    end
                    C_MUL:   state_n = S_MULWAIT;
                    default: state_n = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_n = S_FETCH;
                unique case (cls_q)
                    C_ALU: begin
                        WR_En = 1'b1;
                        PC_En = 1'b1;
                    end
                    C_CMP: begin
                        Flag_En = 1'b1;
                        PC_En   = 1'b1;
                    end
                    C_BR: begin
                        PC_En       = 1'b1;
                        Take_Branch = take;
                    end
                    C_LDR, C_STR: state_n = S_MEM;
                    default: ;
                endcase
            end
            S_MEM: begin
                Mem_Req = 1'b1;
                WM_En   = (cls_q == C_STR);
                if (Mem_Ready) begin
                    if (cls_q == C_STR) begin
                        PC_En   = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wd_tc) begin
                    set_bus_err = 1'b1;
                    state_n     = S_HALT;
                end
            end
            S_WB: begin
                WR_En   = 1'b1;
                PC_En   = 1'b1;
                state_n = S_FETCH;
            end
            S_MULWAIT: begin
                Mul_Start = (wd_cnt == '0);
                if (Mul_Done) begin
                    WR_En   = 1'b1;
                    PC_En   = 1'b1;
                    state_n = S_FETCH;
                end else if (wd_tc) begin
                    set_bus_err = 1'b1;
                    state_n     = S_HALT;
                end
            end
            S_HALT:  ;
            default: state_n = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NOP;
            dec_q     <= NOP_WORD;
            z_q       <= 1'b0;
            ill_q     <= 1'b0;
            bus_err_q <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == S_DECODE) begin
                cls_q <= cls_n;
                dec_q <= dec_n;
            end
            if (Flag_En) begin
                z_q <= Zero;
            end
            if (set_ill) begin
                ill_q <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
            // watchdog counts dwell cycles within one wait state only
            if (state_n != state_q) begin
                wd_cnt <= '0;
            end else if (state_q == S_FETCH || state_q == S_MEM || state_q == S_MULWAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign Illegal = ill_q;
    assign Bus_Err = bus_err_q;
    assign Halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected strobes/decode words are
// queued as stimulus is driven and compared when the DUT presents its outputs.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wd_rst_n = 1'b0;
    logic [3:0] op;
    logic [1:0] fn;
    logic       zero, mem_ready, mul_done, wd_rdy;

    logic [1:0] branch, ext_sel, wd_sel;
    logic       opb_sel, alu_func, wr_en, wm_en, ir_en, pc_en, take_branch;
    logic       flag_en, mem_req, mul_start, illegal, bus_err, halted;

    logic [1:0] w_branch, w_ext_sel, w_wd_sel;
    logic       w_opb_sel, w_alu_func, w_wr_en, w_wm_en, w_ir_en, w_pc_en, w_take_branch;
    logic       w_flag_en, w_mem_req, w_mul_start, w_illegal, w_bus_err, w_halted;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OP_W(4), .FN_W(2), .WAIT_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(op), .Funct(fn), .Zero(zero),
        .Mem_Ready(mem_ready), .Mul_Done(mul_done),
        .Branch(branch), .Ext_Sel(ext_sel), .Opb_Sel(opb_sel), .Alu_Func(alu_func),
        .WD_Sel(wd_sel), .WR_En(wr_en), .WM_En(wm_en), .IR_En(ir_en), .PC_En(pc_en),
        .Take_Branch(take_branch), .Flag_En(flag_en), .Mem_Req(mem_req),
        .Mul_Start(mul_start), .Illegal(illegal), .Bus_Err(bus_err), .Halted(halted)
    );

    multicycle_control_unit #(.OP_W(4), .FN_W(2), .WAIT_MAX(4)) dut_wd (
        .clk(clk), .rst_n(wd_rst_n), .OpCode(op), .Funct(fn), .Zero(zero),
        .Mem_Ready(wd_rdy), .Mul_Done(1'b0),
        .Branch(w_branch), .Ext_Sel(w_ext_sel), .Opb_Sel(w_opb_sel), .Alu_Func(w_alu_func),
        .WD_Sel(w_wd_sel), .WR_En(w_wr_en), .WM_En(w_wm_en), .IR_En(w_ir_en), .PC_En(w_pc_en),
        .Take_Branch(w_take_branch), .Flag_En(w_flag_en), .Mem_Req(w_mem_req),
        .Mul_Start(w_mul_start), .Illegal(w_illegal), .Bus_Err(w_bus_err), .Halted(w_halted)
    );

    localparam logic [10:0] WR = 11'h400, WM = 11'h200, IR = 11'h100, PC = 11'h080;
    localparam logic [10:0] TK = 11'h040, FL = 11'h020, MR = 11'h010, MS = 11'h008;
    localparam logic [10:0] IL = 11'h004, BE = 11'h002, HL = 11'h001, NO = 11'h000;

    typedef struct {
        string      tag;
        logic [10:0] strb;
        logic [7:0] dec;
        bit         chk_dec;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    logic [10:0] obs_strb;
    logic [7:0]  obs_dec;
    assign obs_strb = {wr_en, wm_en, ir_en, pc_en, take_branch, flag_en, mem_req,
                       mul_start, illegal, bus_err, halted};
    assign obs_dec  = {branch, ext_sel, opb_sel, alu_func, wd_sel};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one cycle of stimulus, driven just after a falling edge
    task automatic step(input string tag, input logic rst, input logic mr, input logic md,
                        input logic z, input logic [10:0] strb, input logic [7:0] dec,
                        input bit cd);
        exp_t e;
        rst_n     = rst;
        mem_ready = mr;
        mul_done  = md;
        zero      = z;
        e.tag     = tag;
        e.strb    = strb;
        e.dec     = dec;
        e.chk_dec = cd;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [3:0] o, input logic [1:0] f);
        op = o;
        fn = f;
        step("fetch", 1'b1, 1'b1, 1'b0, 1'b0, MR | IR, 8'h00, 1'b0);
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({e.tag, "_strb"}, 32'(obs_strb), 32'(e.strb));
            if (e.chk_dec) check_val({e.tag, "_dec"}, 32'(obs_dec), 32'(e.dec));
        end
    end

    initial begin
        op = 4'd7; fn = 2'd0; zero = 1'b0; mem_ready = 1'b0; mul_done = 1'b0; wd_rdy = 1'b0;
        @(negedge clk);
        step("reset", 1'b0, 1'b0, 1'b1, 1'b0, MR, 8'hF0, 1'b1);

        // add with stale Mul_Done and Zero in EXEC
        fetch(4'd0, 2'd0);
        step("add_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hF0, 1'b1);
        step("add_exec", 1'b1, 1'b1, 1'b1, 1'b1, WR | PC, 8'hC0, 1'b1);
        fetch(4'd0, 2'd1);
        step("addi_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hC0, 1'b1);
        step("addi_exec", 1'b1, 1'b1, 1'b0, 1'b0, WR | PC, 8'hD8, 1'b1);
        fetch(4'd0, 2'd2);
        step("sub_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hD8, 1'b1);
        step("sub_exec", 1'b1, 1'b1, 1'b0, 1'b0, WR | PC, 8'hC4, 1'b1);

        // cmp-imm sets Z, then JEQ taken / JNE not taken
        fetch(4'd1, 2'd3);
        step("cmpi_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hC4, 1'b1);
        step("cmpi_exec", 1'b1, 1'b1, 1'b0, 1'b1, FL | PC, 8'hDC, 1'b1);
        fetch(4'd4, 2'd0);
        step("jeq_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hDC, 1'b1);
        step("jeq_exec", 1'b1, 1'b1, 1'b0, 1'b0, PC | TK, 8'h30, 1'b1);
        fetch(4'd5, 2'd0);
        step("jne_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'h30, 1'b1);
        step("jne_exec", 1'b1, 1'b1, 1'b0, 1'b1, PC, 8'h70, 1'b1);

        // cmp clears Z, then JEQ not taken / JNE taken / JMP always
        fetch(4'd1, 2'd2);
        step("cmp_dec",  1'b1, 1'b1, 1'b0, 1'b1, NO, 8'h70, 1'b1);
        step("cmp_exec", 1'b1, 1'b1, 1'b0, 1'b0, FL | PC, 8'hC4, 1'b1);
        fetch(4'd4, 2'd0);
        step("jeq0_dec",  1'b1, 1'b1, 1'b0, 1'b1, NO, 8'hC4, 1'b1);
        step("jeq0_exec", 1'b1, 1'b1, 1'b0, 1'b1, PC, 8'h30, 1'b1);
        fetch(4'd5, 2'd0);
        step("jne0_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'h30, 1'b1);
        step("jne0_exec", 1'b1, 1'b1, 1'b0, 1'b0, PC | TK, 8'h70, 1'b1);
        fetch(4'd6, 2'd0);
        step("jmp_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'h70, 1'b1);
        step("jmp_exec", 1'b1, 1'b1, 1'b0, 1'b0, PC | TK, 8'hB0, 1'b1);

        fetch(4'd7, 2'd0);
        step("nop_dec", 1'b1, 1'b1, 1'b0, 1'b0, PC, 8'hB0, 1'b1);

        // LDR: three MEM cycles without Mem_Ready, ready on the fourth
        fetch(4'd2, 2'd0);
        step("ldr_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hF0, 1'b1);
        step("ldr_exec", 1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hE9, 1'b1);
        for (int i = 0; i < 3; i++)
            step("ldr_memwait", 1'b1, 1'b0, 1'b0, 1'b0, MR, 8'hE9, 1'b1);
        step("ldr_memdone", 1'b1, 1'b1, 1'b0, 1'b0, MR, 8'hE9, 1'b1);
        step("ldr_wb",      1'b1, 1'b0, 1'b0, 1'b0, WR | PC, 8'hE9, 1'b1);

        fetch(4'd3, 2'd0);
        step("str_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hE9, 1'b1);
        step("str_exec", 1'b1, 1'b0, 1'b0, 1'b0, NO, 8'hE8, 1'b1);
        for (int i = 0; i < 2; i++)
            step("str_memwait", 1'b1, 1'b0, 1'b0, 1'b0, MR | WM, 8'hE8, 1'b1);
        step("str_memdone", 1'b1, 1'b1, 1'b0, 1'b0, MR | WM | PC, 8'hE8, 1'b1);

        // MODMUL: ten cycles without Mul_Done, stale Mem_Ready present
        fetch(4'd8, 2'd0);
        step("mul_dec",   1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hE8, 1'b1);
        step("mul_start", 1'b1, 1'b1, 1'b0, 1'b0, MS, 8'hC2, 1'b1);
        for (int i = 0; i < 9; i++)
            step("mul_wait", 1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hC2, 1'b1);
        step("mul_done", 1'b1, 1'b0, 1'b1, 1'b0, WR | PC, 8'hC2, 1'b1);

        fetch(4'd8, 2'd1);
        step("mul1_dec",  1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hC2, 1'b1);
        step("mul1_done", 1'b1, 1'b0, 1'b1, 1'b0, MS | WR | PC, 8'hC2, 1'b1);

        // asynchronous reset in MULWAIT, sampled before the next rising edge
        fetch(4'd8, 2'd0);
        step("mulr_dec",   1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hC2, 1'b1);
        step("mulr_start", 1'b1, 1'b0, 1'b0, 1'b0, MS, 8'hC2, 1'b1);
        step("mulr_reset", 1'b0, 1'b0, 1'b0, 1'b0, MR, 8'hF0, 1'b1);

        // op1/f0 is illegal
        fetch(4'd1, 2'd0);
        step("ill1_dec", 1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hF0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("ill1_halt", 1'b1, 1'b1, 1'b1, 1'b1, IL | HL, 8'h00, 1'b0);
        step("ill1_reset", 1'b0, 1'b0, 1'b0, 1'b0, MR, 8'hF0, 1'b1);

        fetch(4'd9, 2'd0);
        step("ill9_dec", 1'b1, 1'b1, 1'b0, 1'b0, NO, 8'hF0, 1'b1);
        for (int i = 0; i < 2; i++)
            step("ill9_halt", 1'b1, 1'b1, 1'b1, 1'b0, IL | HL, 8'h00, 1'b0);
        step("ill9_reset", 1'b0, 1'b0, 1'b0, 1'b0, MR, 8'hF0, 1'b1);

        @(negedge clk);
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        // watchdog with WAIT_MAX = 4 and no memory response
        op = 4'd7;
        wd_rst_n = 1'b1;
        #2;
        check_val("wd_fetch1_req", 32'({w_mem_req, w_bus_err, w_halted}), 32'b100);
        repeat (3) @(negedge clk);
        #2;
        check_val("wd_fetch4_req", 32'({w_mem_req, w_bus_err, w_halted}), 32'b100);
        @(negedge clk);
        #2;
        check_val("wd_timeout", 32'({w_mem_req, w_bus_err, w_halted}), 32'b011);
        wd_rst_n = 1'b0;
        #1;
        check_val("wd_reset_clear", 32'({w_mem_req, w_bus_err, w_halted}), 32'b100);

        // Mem_Ready on the fourth FETCH cycle beats the timeout
        @(negedge clk);
        wd_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wd_rdy = 1'b1;
        #2;
        check_val("wd_edge_ir", 32'({w_ir_en, w_bus_err}), 32'b10);
        @(negedge clk);
        wd_rdy = 1'b0;
        #2;
        check_val("wd_edge_decode", 32'({w_mem_req, w_bus_err, w_halted}), 32'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", n_chk);
        $fatal(1);
    end

endmodule
